vip_yuv422_to_444: RTL

- Upstream neighbour of the YUV-to-RGB stage in the VIP chain. It sits between the camera/ISP YUV422 output and the 4:4:4 Y/U/V inputs that the RGB converter consumes.
- Takes a per-pixel {Y, C} stream in which chroma alternates Cb/Cr across horizontal pixel pairs. Emits full Y, U, V on every pixel, with href/vsync delayed to match.

---
 rtl/vip_pkg.sv | 25 ++
 rtl/vip_sync_delay.sv | 42 ++++
 rtl/vip_yuv422_to_444.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vip_pkg.sv
// Shared constants and types for the VIP YUV422 -> YUV444 chroma stage.
package vip_pkg;

  localparam int unsigned VIP_422_LAT        = 2;
  localparam int unsigned VIP_422_LAT_INTERP = 4;

  // Phase of the pixel currently on the input within its horizontal pair.
  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  // Last pixel of a pair that was captured.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } pair_st_t;

  // Mid-scale chroma value used when a component is missing.
  function automatic logic [31:0] neutral(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// DEPTH-stage shift register for href, vsync and luma, shared by VIP stages.
module vip_sync_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         in_href,
  input  logic         in_vsync,
  input  logic [W-1:0] in_y,
  output logic         out_href,
  output logic         out_vsync,
  output logic [W-1:0] out_y
);

  logic [DEPTH-1:0] href_sr;
  logic [DEPTH-1:0] vsync_sr;
  logic [W-1:0]     y_sr [DEPTH];

  // Shift all three streams one stage per pclk.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_sr  <= '0;
      vsync_sr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) y_sr[i] <= '0;
    end else begin
      href_sr[0]  <= in_href;
      vsync_sr[0] <= in_vsync;
      y_sr[0]     <= in_y;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        href_sr[i]  <= href_sr[i-1];
        vsync_sr[i] <= vsync_sr[i-1];
        y_sr[i]     <= y_sr[i-1];
      end
    end
  end

  assign out_href  = href_sr[DEPTH-1];
  assign out_vsync = vsync_sr[DEPTH-1];
  assign out_y     = y_sr[DEPTH-1];

endmodule

// File: rtl/vip_yuv422_to_444.sv
// YUV422 {Y,C} stream to per-pixel Y/U/V with chroma replication.
// Optional macro VIP_YUV422_INTERP_EN: interpolate odd-pixel chroma, LAT = 4.
module vip_yuv422_to_444
  import vip_pkg::*;
#(
  parameter int unsigned BITS     = 8,
  parameter int unsigned WIDTH    = 1280,
  parameter int unsigned HEIGHT   = 960,
  parameter bit          CB_FIRST = 1'b1
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_c,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_y,
  output logic [BITS-1:0] out_u,
  output logic [BITS-1:0] out_v
);

  if (WIDTH == 0 || HEIGHT == 0) begin : g_bad_geometry
    $error("vip_yuv422_to_444: WIDTH and HEIGHT must be non-zero");
  end

`ifdef VIP_YUV422_INTERP_EN
  localparam int unsigned LAT = VIP_422_LAT_INTERP;
`else
  localparam int unsigned LAT = VIP_422_LAT;
`endif

  localparam logic [BITS-1:0] NEUTRAL = BITS'(neutral(BITS));

  phase_t          ph;
  pair_st_t        st;
  logic [BITS-1:0] c0_hold;
  logic [BITS-1:0] pair_u, pair_v;
  logic            pair_full;
  logic            href_d, vsync_d;
  logic [BITS-1:0] y_d;
  logic [BITS-1:0] u_sel, v_sel;

  // Phase tracking and pair FSM; pair chroma is loaded when the odd pixel
  // arrives, which is the same edge that presents the even pixel at LAT 2.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= PH_EVEN;
      st        <= ST_IDLE;
      c0_hold   <= '0;
      pair_u    <= '0;
      pair_v    <= '0;
      pair_full <= 1'b0;
    end else if (in_href) begin
      ph <= (ph == PH_EVEN) ? PH_ODD : PH_EVEN;
      if (ph == PH_EVEN) begin
        c0_hold <= in_c;
        st      <= ST_EVEN;
      end else begin
        pair_u    <= CB_FIRST ? c0_hold : in_c;
        pair_v    <= CB_FIRST ? in_c : c0_hold;
        pair_full <= 1'b1;
        st        <= ST_ODD;
      end
    end else begin
      ph <= PH_EVEN;
      st <= ST_IDLE;
      // Lone trailing pixel: keep its own component, neutral for the other.
      if (st == ST_EVEN) begin
        pair_u    <= CB_FIRST ? c0_hold : NEUTRAL;
        pair_v    <= CB_FIRST ? NEUTRAL : c0_hold;
        pair_full <= 1'b0;
      end
    end
  end

  vip_sync_delay #(.DEPTH(LAT), .W(BITS)) u_sync (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_y      (in_y),
    .out_href  (href_d),
    .out_vsync (vsync_d),
    .out_y     (y_d)
  );

`ifdef VIP_YUV422_INTERP_EN
  phase_t          ph1, ph2, ph3, ph4;
  logic            h1, h2, h3;
  logic            full3;
  logic [BITS-1:0] u3, v3, u4, v4;

  function automatic logic [BITS-1:0] avg(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS:0] s;
    s = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, 1'b1};
    return s[BITS:1];
  endfunction

  // Two extra chroma stages; stage 3 then holds the following pair's chroma
  // whenever stage 4 shows an odd pixel that has a neighbour pair.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ph1 <= PH_EVEN; ph2 <= PH_EVEN; ph3 <= PH_EVEN; ph4 <= PH_EVEN;
      h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
      full3 <= 1'b0;
      u3 <= '0; v3 <= '0; u4 <= '0; v4 <= '0;
    end else begin
      ph1   <= in_href ? ph : PH_EVEN;
      ph2   <= ph1;
      ph3   <= ph2;
      ph4   <= ph3;
      h1    <= in_href;
      h2    <= h1;
      h3    <= h2;
      full3 <= pair_full;
      u3    <= pair_u;
      v3    <= pair_v;
      u4    <= u3;
      v4    <= v3;
    end
  end

  // Odd pixels average with the next full pair; otherwise replicate.
  always_comb begin
    u_sel = u4;
    v_sel = v4;
    if (ph4 == PH_ODD && h3 && full3) begin
      u_sel = avg(u4, u3);
      v_sel = avg(v4, v3);
    end
  end
`else
  // Pair registers are already aligned to the LAT 2 output.
  always_comb begin
    u_sel = pair_u;
    v_sel = pair_v;
  end
`endif

  // Blank all components outside the active line.
  always_comb begin
    out_href  = href_d;
    out_vsync = vsync_d;
    out_y     = href_d ? y_d   : '0;
    out_u     = href_d ? u_sel : '0;
    out_v     = href_d ? v_sel : '0;
  end

endmodule
